// File: rtl/dmem_if.sv
// Data-memory request/response bus.
// Core drives requests; responder answers.
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr,
    output req_wdata, req_funct3, resp_ready,
    input  req_ready, resp_valid,
    input  resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr,
    input  req_wdata, req_funct3, resp_ready,
    output req_ready, resp_valid,
    output resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder with fixed latency.
// One request in flight; byte/half/word sizing.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input logic   clk,
  input logic   rst_n,
  dmem_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        l_write;
  logic [31:0] l_addr;
  logic [31:0] l_wdata;
  logic [2:0]  l_f3;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0] off;
  logic [AW-1:0] idx;
  logic [1:0]  lane;
  logic        sz_b;
  logic        sz_h;
  logic        sz_w;
  logic        err;
  logic [31:0] word;
  logic [31:0] shifted;
  logic [31:0] ld_data;
  logic [31:0] st_data;
  logic [3:0]  be;
  logic        commit;

  assign bus.req_ready = (state == IDLE) && rst_n;

  assign off  = l_addr - BASE_ADDR;
  assign idx  = off[AW+1:2];
  assign lane = off[1:0];
  assign word = mem[idx];

  assign commit = (state == BUSY) && (cnt == 4'd0);

  // Decode access size and reject bad requests.
  always_comb begin
    sz_b = (l_f3[1:0] == 2'd0);
    sz_h = (l_f3[1:0] == 2'd1);
    sz_w = (l_f3 == 3'd2);
    err  = 1'b0;
    if (l_f3 == 3'd3 || l_f3 == 3'd6 ||
        l_f3 == 3'd7)
      err = 1'b1;
    if (l_write && l_f3[2])
      err = 1'b1;
    if (sz_h && lane[0])
      err = 1'b1;
    if (sz_w && lane != 2'd0)
      err = 1'b1;
    if (off[31:AW+2] != '0)
      err = 1'b1;
  end

  // Extract the addressed lane and extend it.
  always_comb begin
    shifted = word >> {lane, 3'b000};
    ld_data = shifted;
    unique case (1'b1)
      sz_b: begin
        if (l_f3[2])
          ld_data = {24'b0, shifted[7:0]};
        else
          ld_data = {{24{shifted[7]}},
                     shifted[7:0]};
      end
      sz_h: begin
        if (l_f3[2])
          ld_data = {16'b0, shifted[15:0]};
        else
          ld_data = {{16{shifted[15]}},
                     shifted[15:0]};
      end
      default: ld_data = shifted;
    endcase
  end

  // Replicate store data and pick byte enables.
  always_comb begin
    be      = 4'b1111;
    st_data = l_wdata;
    unique case (1'b1)
      sz_b: begin
        be      = 4'b0001 << lane;
        st_data = {4{l_wdata[7:0]}};
      end
      sz_h: begin
        be      = lane[1] ? 4'b1100 : 4'b0011;
        st_data = {2{l_wdata[15:0]}};
      end
      default: begin
        be      = 4'b1111;
        st_data = l_wdata;
      end
    endcase
  end

  // Backing store; written only on the commit edge.
  always_ff @(posedge clk) begin
    if (commit && l_write && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i])
          mem[idx][8*i +: 8] <= st_data[8*i +: 8];
      end
    end
  end

  // Request/latency/response sequencing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= 4'd0;
      l_write        <= 1'b0;
      l_addr         <= 32'h0;
      l_wdata        <= 32'h0;
      l_f3           <= 3'd0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= 32'h0;
      bus.resp_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            l_write <= bus.req_write;
            l_addr  <= bus.req_addr;
            l_wdata <= bus.req_wdata;
            l_f3    <= bus.req_funct3;
            cnt     <= 4'(LATENCY - 1);
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            state          <= RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= err;
            bus.resp_rdata <= (err || l_write) ?
                              32'h0 : ld_data;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            state          <= IDLE;
            bus.resp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder.
// Byte-array reference model.
module tb_dmem_responder;
  localparam int unsigned DW   = 1024;
  localparam int unsigned LAT  = 2;
  localparam logic [31:0] BASE = 32'h0;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  dmem_if bus();

  dmem_responder #(
    .DEPTH_WORDS(DW),
    .LATENCY(LAT),
    .BASE_ADDR(BASE)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  typedef struct {
    logic [31:0] rd;
    logic        e;
    int          acc;
  } exp_t;

  exp_t q[$];
  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  int done  = 0;
  int seen  = 0;
  logic [7:0] mdl [DW*4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h",
               nm, act, exp);
    end
  endtask

  function automatic void model(
    input  logic        w,
    input  logic [31:0] a,
    input  logic [31:0] d,
    input  logic [2:0]  f,
    input  bit          apply,
    output logic [31:0] rd,
    output logic        e);
    int unsigned sz;
    logic [31:0] off;
    logic [31:0] v;
    sz  = (f == 0 || f == 4) ? 1 :
          (f == 1 || f == 5) ? 2 : 4;
    off = a - BASE;
    e   = (f == 3 || f == 6 || f == 7) ||
          (w && f > 2) ||
          (a % sz != 0) ||
          !(off < DW * 4);
    rd  = 32'h0;
    if (!e) begin
      if (w) begin
        if (apply)
          for (int i = 0; i < int'(sz); i++)
            mdl[off + i] = d[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < int'(sz); i++)
          v[8*i +: 8] = mdl[off + i];
        if (f < 4)
          for (int j = 8 * sz; j < 32; j++)
            v[j] = v[8*sz - 1];
        rd = v;
      end
    end
  endfunction

  // Response monitor and scoreboard check.
  initial begin : mon
    bit in_resp;
    exp_t x;
    logic [31:0] c_rd;
    logic c_e;
    in_resp = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_resp = 0;
      end else if (bus.resp_valid) begin
        if (!in_resp) begin
          if (q.size() == 0) begin
            chk("spurious_resp",
                {31'b0, bus.resp_valid}, 32'd0);
          end else begin
            x = q.pop_front();
            chk("rdata", bus.resp_rdata, x.rd);
            chk("err", {31'b0, bus.resp_err},
                {31'b0, x.e});
            chk("latency", cyc - x.acc, LAT);
          end
          c_rd    = bus.resp_rdata;
          c_e     = bus.resp_err;
          in_resp = 1;
          seen++;
        end else begin
          chk("hold_rdata", bus.resp_rdata, c_rd);
          chk("hold_err", {31'b0, bus.resp_err},
              {31'b0, c_e});
        end
        chk("ready_in_resp",
            {31'b0, bus.req_ready}, 32'd0);
        if (bus.resp_ready) begin
          in_resp = 0;
          done++;
        end
      end
    end
  end

  task automatic accept(input logic w,
                        input logic [31:0] a,
                        input logic [31:0] d,
                        input logic [2:0] f,
                        output bit ok);
    bus.req_write  = w;
    bus.req_addr   = a;
    bus.req_wdata  = d;
    bus.req_funct3 = f;
    bus.req_valid  = 1'b1;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok)
      chk("accept_timeout",
          {31'b0, bus.req_ready}, 32'd1);
    else begin
      @(posedge clk);
      #1;
    end
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'($urandom);
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
    bus.req_funct3 = 3'($urandom);
  endtask

  task automatic do_req(input logic w,
                        input logic [31:0] a,
                        input logic [31:0] d,
                        input logic [2:0] f,
                        input int hold);
    bit ok;
    exp_t x;
    int s0;
    int d0;
    int k;
    bus.resp_ready = (hold == 0);
    s0 = seen;
    d0 = done;
    accept(w, a, d, f, ok);
    if (!ok) return;
    model(w, a, d, f, 1, x.rd, x.e);
    x.acc = cyc;
    q.push_back(x);
    if (hold > 0) begin
      k = 0;
      while (seen == s0 && k < 100) begin
        @(posedge clk);
        #1;
        k++;
      end
      repeat (hold) @(posedge clk);
      #1;
      bus.resp_ready = 1'b1;
    end
    k = 0;
    while (done == d0 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (done == d0) begin
      chk("resp_timeout", done - d0, 1);
      q.delete();
    end else begin
      chk("ready_after",
          {31'b0, bus.req_ready}, 32'd1);
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin : main
    logic [2:0] legal [5];
    logic [2:0] f;
    logic [31:0] a;
    bit ok;
    int hold;
    legal = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.req_funct3 = 3'd0;
    bus.resp_ready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'b0, bus.resp_valid}, 0);
    chk("rst_ready", {31'b0, bus.req_ready}, 0);
    chk("rst_rdata", bus.resp_rdata, 0);
    chk("rst_err", {31'b0, bus.resp_err}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_req(1, 32'h10, 32'hDEADBEEF, 3'd2, 0);
    do_req(0, 32'h10, 32'h0, 3'd2, 0);
    do_req(0, 32'h13, 32'h0, 3'd0, 0);
    do_req(0, 32'h13, 32'h0, 3'd4, 0);
    do_req(0, 32'h12, 32'h0, 3'd1, 0);
    do_req(0, 32'h10, 32'h0, 3'd5, 0);
    do_req(1, 32'h11, 32'h55, 3'd0, 0);
    do_req(0, 32'h10, 32'h0, 3'd2, 0);
    do_req(0, 32'h12, 32'h0, 3'd2, 0);
    do_req(0, 32'h11, 32'h0, 3'd1, 0);
    do_req(0, 32'h10, 32'h0, 3'd3, 0);
    do_req(0, BASE + DW * 4, 32'h0, 3'd2, 0);
    do_req(1, 32'h10, 32'h0, 3'd4, 0);
    do_req(0, 32'h10, 32'h0, 3'd2, 0);
    do_req(0, 32'h10, 32'h0, 3'd2, 5);

    do_req(1, 32'h20, 32'hCAFEF00D, 3'd2, 0);
    accept(1, 32'h20, 32'h1234, 3'd2, ok);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", {31'b0, bus.resp_valid}, 0);
    chk("abort_ready", {31'b0, bus.req_ready}, 0);
    chk("abort_rdata", bus.resp_rdata, 0);
    chk("abort_err", {31'b0, bus.resp_err}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (LAT + 4) @(posedge clk);
    #1;
    do_req(0, 32'h20, 32'h0, 3'd2, 0);

    for (int i = 0; i < 32; i++)
      do_req(1, BASE + 32'(i * 4), $urandom,
             3'd2, 0);

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 9) < 8)
        f = legal[$urandom_range(0, 4)];
      else
        f = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0)
        a = BASE + DW * 4 +
            32'($urandom_range(0, 255));
      else
        a = BASE + 32'($urandom_range(0, 127));
      hold = ($urandom_range(0, 3) == 0) ?
             $urandom_range(1, 3) : 0;
      do_req(1'($urandom_range(0, 1)), a,
             $urandom, f, hold);
    end

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Memory-side responder for the core's data-memory port. It accepts one load or store request at a time over a valid/ready handshake, applies RISC-V byte/half/word sizing (funct3), and returns a response after a configurable latency. The response carries sign- or zero-extended load data, or a store acknowledge, plus an error flag. It lets the core be exercised against a non-zero-latency memory in place of the single-cycle data memory.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words of backing storage (power of two)
LATENCY, 2, rising edges from the accepting edge to resp_valid rising (legal range 1..15)
BASE_ADDR, 32'h0000_0000, byte address of word 0 (aligned to DEPTH_WORDS*4)

Ports:
clk  input  1  clock, rising-edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_write  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data, right-justified (sb uses [7:0], sh uses [15:0])
req_funct3  input  3  RISC-V funct3: 0 lb/sb, 1 lh/sh, 2 lw/sw, 4 lbu, 5 lhu
resp_valid  output  1  response present
resp_ready  input  1  requester accepts response
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_err  output  1  request was rejected (misaligned, out of range or illegal funct3)

Behaviour:
- Reset is asynchronous and active-low: one clock (clk), reset rst_n. While rst_n=0: state=IDLE, counter=0, resp_valid=0, resp_rdata=0, resp_err=0, req_ready=0. Storage contents are not reset.
- FSM has three states: IDLE, BUSY, RESP. req_ready = (state==IDLE) && rst_n, derived combinationally from state only and never from req_valid.
- IDLE: on an edge with req_valid&&req_ready, latch write/addr/wdata/funct3 and go to BUSY with counter=LATENCY-1.
- BUSY: on each edge, if counter==0 go to RESP, otherwise decrement. resp_valid therefore rises exactly LATENCY edges after the accepting edge.
- On the BUSY->RESP edge:
  - Perform the error check.
  - Legal store: write the selected byte lanes; other lanes are unchanged.
  - Legal load: register the extended data into resp_rdata.
  - Set resp_err accordingly.
- RESP: hold resp_valid, resp_rdata and resp_err stable until an edge with resp_ready=1, then go to IDLE and clear resp_valid. Only one request is outstanding. The earliest next acceptance is the cycle after the response handshake.
- Error conditions:
  - funct3 is 3, 6 or 7.
  - A store has funct3 greater than 2.
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - (addr-BASE_ADDR)>>2 >= DEPTH_WORDS.
  An error suppresses the write and forces resp_rdata=0.
- Lanes: the byte lane is addr[1:0]; the halfword lane is addr[1]. lb/lh sign-extend from bit 7/15; lbu/lhu zero-extend.
- Request inputs are ignored outside IDLE. Holding req_valid high in BUSY or RESP has no effect.
- Reset asserted in BUSY aborts the transaction: no write occurs and no response is produced. Reset asserted in RESP drops the response; a write that already committed stays committed.

Test Plan:
- sw addr 0x10 data 0xDEADBEEF, then lw 0x10 with resp_ready=1 (LATENCY=2) -> each resp_valid rises 2 edges after acceptance; load returns 0xDEADBEEF with resp_err=0; store response rdata=0.
- After that word is in memory: lb 0x13 -> 0xFFFFFFDE; lbu 0x13 -> 0x000000DE; lh 0x12 -> 0xFFFFDEAD; lhu 0x10 -> 0x0000BEEF.
- sb 0x11 data 0x55, then lw 0x10 -> 0xDEAD55EF (only lane 1 changes).
- lw 0x12, lh 0x11, funct3=3, and lw at BASE_ADDR+DEPTH_WORDS*4 -> each returns resp_err=1 with rdata=0; a following lw 0x10 confirms memory is unchanged.
- Hold resp_ready=0 for 5 cycles in RESP -> resp_valid and data stay stable and req_ready stays 0; after resp_ready=1, req_ready returns high on the next cycle.
- Issue sw 0x20 data 0x1234, pulse rst_n low during BUSY -> outputs clear immediately and no response is produced; a following lw 0x20 returns the pre-test value, not 0x1234.
